// File: rtl/sort4_pkg.sv
// Shared definitions for the four-byte sorting controller: state encoding,
// comparator result codes and the fixed compare-swap schedule.
package sort4_pkg;

  localparam int N_ELEM  = 4;
  localparam int N_STEPS = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SORT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  // Lower slot index of the pair compared at each step; the partner is index+1.
  localparam logic [1:0] STEP_LO [N_STEPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};

  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

endpackage

// File: rtl/sort4_ctrl_if.sv
// Load/result bus of the sorter. Load handshake: a byte transfers on every
// rising edge where iValid and oReady are both high; oReady never depends on iValid.
interface sort4_ctrl_if;
  import sort4_pkg::*;

  logic        iStart;
  logic        iValid;
  logic [7:0]  iData;
  logic        oReady;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oSorted;
  logic [2:0]  oSwaps;
  state_t      dbg_state;

  modport master (
    output iStart, iValid, iData,
    input  oReady, oBusy, oDone, oSorted, oSwaps, dbg_state
  );

  modport slave (
    input  iStart, iValid, iData,
    output oReady, oBusy, oDone, oSorted, oSwaps, dbg_state
  );

endinterface

// File: rtl/cmp8_unit.sv
// Combinational unsigned 8-bit magnitude comparator with one-hot {gt, lt, eq} result.
module cmp8_unit
  import sort4_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [2:0] res
);

  always_comb begin
    res = CMP_EQ;
    if (a > b)      res = CMP_GT;
    else if (a < b) res = CMP_LT;
  end

endmodule

// File: rtl/sort4_ctrl.sv
// Loads four bytes, bubble-sorts them with one shared comparator over six
// fixed steps, then publishes the ascending word and swap count with a done pulse.
module sort4_ctrl
  import sort4_pkg::*;
(
  input  logic         iClk,
  input  logic         iRst_n,
  sort4_ctrl_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_slot [N_ELEM];
  logic [7:0]  w_slot_nxt [N_ELEM];
  logic [1:0]  r_idx;
  logic [2:0]  r_step;
  logic [2:0]  r_swaps;
  logic [31:0] r_sorted;
  logic [2:0]  r_out_swaps;

  logic [1:0]  w_lo;
  logic [1:0]  w_hi;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [2:0]  w_cmp;
  logic        w_swap;
  logic [2:0]  w_swaps_nxt;
  logic        w_load_fire;
  logic        w_last_byte;

  assign w_lo = STEP_LO[r_step];
  assign w_hi = w_lo + 2'd1;
  assign w_a  = r_slot[w_lo];
  assign w_b  = r_slot[w_hi];

  cmp8_unit u_cmp (
    .a   (w_a),
    .b   (w_b),
    .res (w_cmp)
  );

  // Swap only on strictly greater, so equal bytes keep their order.
  assign w_swap      = (w_cmp == CMP_GT);
  assign w_swaps_nxt = r_swaps + {2'b00, w_swap};
  assign w_load_fire = (r_state == S_LOAD) && bus.iValid;
  assign w_last_byte = w_load_fire && (r_idx == 2'd3);

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) w_slot_nxt[i] = r_slot[i];
    if (w_swap) begin
      w_slot_nxt[w_lo] = w_b;
      w_slot_nxt[w_hi] = w_a;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.iStart) w_state_nxt = S_LOAD;
      S_LOAD: if (w_last_byte) w_state_nxt = S_SORT;
      S_SORT: if (r_step == LAST_STEP) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = bus.iStart ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < N_ELEM; i++) r_slot[i] <= 8'h00;
      r_idx       <= 2'd0;
      r_step      <= 3'd0;
      r_swaps     <= 3'd0;
      r_sorted    <= 32'h0;
      r_out_swaps <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.iStart) begin
            r_idx   <= 2'd0;
            r_swaps <= 3'd0;
          end
        end
        S_LOAD: begin
          if (w_load_fire) begin
            r_slot[r_idx] <= bus.iData;
            r_idx         <= r_idx + 2'd1;
            if (w_last_byte) r_step <= 3'd0;
          end
        end
        S_SORT: begin
          for (int i = 0; i < N_ELEM; i++) r_slot[i] <= w_slot_nxt[i];
          r_swaps <= w_swaps_nxt;
          if (r_step == LAST_STEP) begin
            r_step      <= 3'd0;
            r_sorted    <= {w_slot_nxt[3], w_slot_nxt[2], w_slot_nxt[1], w_slot_nxt[0]};
            r_out_swaps <= w_swaps_nxt;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oReady    = (r_state == S_LOAD);
  assign bus.oBusy     = (r_state == S_LOAD) || (r_state == S_SORT);
  assign bus.oDone     = (r_state == S_DONE);
  assign bus.oSorted   = r_sorted;
  assign bus.oSwaps    = r_out_swaps;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: jobs push a reference result on load and the
// result is popped and compared when the done pulse appears.
module tb_sort4_ctrl;
  import sort4_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic [34:0] exp_q[$];

  sort4_ctrl_if bus ();

  sort4_ctrl dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: ascending sort plus inversion count (bubble sort swaps = inversions).
  function automatic logic [34:0] model(input logic [31:0] bytes);
    logic [7:0] v [4];
    logic [7:0] t;
    logic [2:0] inv;
    inv = 3'd0;
    for (int i = 0; i < 4; i++) v[i] = bytes[8*i +: 8];
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i] > v[j]) inv = inv + 3'd1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[j] < v[i]) begin
          t = v[i]; v[i] = v[j]; v[j] = t;
        end
    return {v[3], v[2], v[1], v[0], inv};
  endfunction

  // Driver: bytes[7:0] is loaded first.
  task automatic load_bytes(input logic [31:0] bytes, input int stall);
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && stall > 0) begin
        bus.iValid = 1'b0;
        repeat (stall) tick();
        check("stall_ready", 64'(bus.oReady), 64'd1);
      end
      bus.iValid = 1'b1;
      bus.iData  = bytes[8*i +: 8];
      tick();
    end
    bus.iValid = 1'b0;
    bus.iData  = 8'h00;
  endtask

  task automatic run_job(input logic [31:0] bytes, input bit do_start, input int stall,
                         input bit poke, input bit chain);
    int n;
    logic [34:0] exp;
    if (do_start) begin
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
    end
    check("load_ready", 64'(bus.oReady), 64'd1);
    check("load_busy", 64'(bus.oBusy), 64'd1);
    exp_q.push_back(model(bytes));
    load_bytes(bytes, stall);
    n = 0;
    while (bus.oDone !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        check("sort_busy", 64'(bus.oBusy), 64'd1);
        check("sort_not_ready", 64'(bus.oReady), 64'd0);
      end
      if (poke && n == 2) begin
        bus.iStart = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 8'h00;
      end else if (poke && n == 3) begin
        bus.iStart = 1'b0;
        bus.iValid = 1'b0;
      end
    end
    check("done_latency", 64'(n), 64'd6);
    exp = exp_q.pop_front();
    check("sorted", 64'(bus.oSorted), 64'(exp[34:3]));
    check("swaps", 64'(bus.oSwaps), 64'(exp[2:0]));
    check("done_not_busy", 64'(bus.oBusy), 64'd0);
    if (chain) bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check("done_one_cycle", 64'(bus.oDone), 64'd0);
    check("sorted_held", 64'(bus.oSorted), 64'(exp[34:3]));
    if (chain) check("done_to_load", 64'(bus.dbg_state), 64'(S_LOAD));
    else       check("done_to_idle", 64'(bus.dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.iStart = 1'b0;
    bus.iValid = 1'b0;
    bus.iData  = 8'h00;
    repeat (3) tick();

    check("rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
    check("rst_ready", 64'(bus.oReady), 64'd0);
    check("rst_busy", 64'(bus.oBusy), 64'd0);
    check("rst_done", 64'(bus.oDone), 64'd0);
    check("rst_sorted", 64'(bus.oSorted), 64'd0);
    check("rst_swaps", 64'(bus.oSwaps), 64'd0);
    rst_n = 1'b1;
    tick();

    // Valid while IDLE must not start or load anything.
    bus.iValid = 1'b1;
    bus.iData  = 8'hAA;
    tick();
    bus.iValid = 1'b0;
    check("idle_valid_ignored", 64'(bus.dbg_state), 64'(S_IDLE));

    run_job(32'h20301040, 1'b1, 0, 1'b0, 1'b1);
    run_job(32'h04030201, 1'b0, 0, 1'b0, 1'b0);
    run_job(32'h007F80FF, 1'b1, 0, 1'b0, 1'b0);
    run_job(32'h05050505, 1'b1, 2, 1'b1, 1'b0);

    // Abandoned job: reset lands asynchronously after sort step 3.
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    load_bytes(32'h11223344, 0);
    repeat (3) tick();
    check("pre_rst_sorting", 64'(bus.dbg_state), 64'(S_SORT));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
    check("mid_rst_busy", 64'(bus.oBusy), 64'd0);
    check("mid_rst_done", 64'(bus.oDone), 64'd0);
    check("mid_rst_sorted", 64'(bus.oSorted), 64'd0);
    check("mid_rst_swaps", 64'(bus.oSwaps), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(bus.dbg_state), 64'(S_IDLE));

    run_job(32'h01070309, 1'b1, 0, 1'b0, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
